// File: rtl/axis_adain_packer.sv
// Frames one AdaIN stream as ys, yb, then N*N pass-through pixels with tlast on the final pixel.
// Define AXIS_ADAIN_PACKER_LAST_CHK_EN to flag upstream tlast that disagrees with the pixel count.
module axis_adain_packer #(
  parameter int WIDTH = 48,
  parameter int N_MAX = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       gpio_N_sel,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_ys,
  input  logic [WIDTH-1:0] cfg_yb,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             frame_done,
  output logic             err_last
);
  localparam int CW  = $clog2(N_MAX*N_MAX+1);
  localparam int NW  = $clog2(N_MAX+1);
  localparam int NW2 = 2*NW;

  typedef enum logic [1:0] {S_IDLE, S_YS, S_YB, S_PIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ys_q, ys_d, yb_q, yb_d;
  logic [NW-1:0]    n_q, n_d;
  logic             frame_done_q, frame_done_d;
  logic             err_last_q, err_last_d;

  logic [NW-1:0]    n_dec;
  logic [NW2-1:0]   n_ext;
  logic [CW-1:0]    n_sq;
  logic             pix_last, pix_xfer;

  function automatic logic [NW-1:0] decode_n(input logic [2:0] sel);
    logic [7:0] n;
    case (sel)
      3'd0:    n = 8'd4;
      3'd1:    n = 8'd8;
      3'd2:    n = 8'd16;
      3'd3:    n = 8'd32;
      3'd4:    n = 8'd64;
      default: n = 8'd128;
    endcase
    return NW'(n);
  endfunction

  assign n_dec    = decode_n(gpio_N_sel);
  assign n_ext    = NW2'(n_dec);
  assign n_sq     = CW'(n_ext * n_ext);
  assign pix_last = (cnt_q == CW'(1));
  assign pix_xfer = (state_q == S_PIX) && s_axis_tvalid && m_axis_tready;

  // Output side is purely a function of state so reset clears it immediately.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      S_YS: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = ys_q;
      end
      S_YB: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = yb_q;
      end
      S_PIX: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign m_axis_tlast = (state_q == S_PIX) && pix_last;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = frame_done_q;
  assign err_last     = err_last_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ys_d         = ys_q;
    yb_d         = yb_q;
    n_d          = n_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        ys_d    = cfg_ys;
        yb_d    = cfg_yb;
        n_d     = n_dec;
        cnt_d   = n_sq;
        state_d = S_YS;
      end
      S_YS: if (m_axis_tready) state_d = S_YB;
      S_YB: if (m_axis_tready) state_d = S_PIX;
      S_PIX: if (pix_xfer) begin
        cnt_d = cnt_q - CW'(1);
        if (pix_last) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AXIS_ADAIN_PACKER_LAST_CHK_EN
  always_comb begin
    err_last_d = err_last_q;
    if (pix_xfer && (s_axis_tlast != pix_last)) err_last_d = 1'b1;
  end
  logic unused_sig;
  assign unused_sig = ^n_q;
`else
  always_comb begin
    err_last_d = 1'b0;
  end
  // Upstream tlast is not consulted when the check is compiled out.
  logic unused_sig;
  assign unused_sig = ^{n_q, s_axis_tlast, err_last_q};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ys_q         <= '0;
      yb_q         <= '0;
      n_q          <= '0;
      frame_done_q <= 1'b0;
      err_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ys_q         <= ys_d;
      yb_q         <= yb_d;
      n_q          <= n_d;
      frame_done_q <= frame_done_d;
      err_last_q   <= err_last_d;
    end
  end
endmodule

// File: tb/tb_axis_adain_packer.sv
// Scoreboard bench: frames are modelled as word lists {ys, yb, pixels...}; a monitor pops on each handshake.
module tb_axis_adain_packer;
  localparam int W = 48;
`ifdef AXIS_ADAIN_PACKER_LAST_CHK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [2:0]   gpio_N_sel = '0;
  logic         start = 1'b0;
  logic [W-1:0] cfg_ys = '0, cfg_yb = '0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b0;
  logic         busy, frame_done, err_last;

  axis_adain_packer #(.WIDTH(W), .N_MAX(128)) dut (
    .clk(clk), .rstn(rstn), .gpio_N_sel(gpio_N_sel), .start(start),
    .cfg_ys(cfg_ys), .cfg_yb(cfg_yb),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .busy(busy), .frame_done(frame_done), .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] d; logic l; } word_t;
  word_t        exp_q[$];
  logic [W-1:0] pix_buf[$];
  int           n_chk = 0, n_pass = 0;
  int           fd_cnt = 0, exp_fd = 0;
  bit           stall_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'({$urandom, $urandom});
  endfunction

  // Downstream consumer: random back-pressure when stalls are enabled.
  always @(posedge clk) begin
    #1;
    m_tready = stall_en ? ($urandom_range(7) != 0) : 1'b1;
  end

  // Monitor: compares every handshake against the scoreboard, checks hold-while-stalled.
  logic [W-1:0] prev_d;
  bit           prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall && m_tvalid) chk("hold_data", 64'(m_tdata), 64'(prev_d));
      if (prev_stall) chk("hold_valid", 64'(m_tvalid), 64'(1));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_word: got %h expected none", m_tdata);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("word", 64'({m_tdata, m_tlast}), 64'({e.d, e.l}));
        end
      end
      if (frame_done) fd_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives pix_buf[0..count-1]; tlast on bad_idx if >=0, else on the true last pixel.
  task automatic drive_pix(input int count, input int np, input int bad_idx);
    for (int i = 0; i < count; i++) begin
      bit done = 1'b0;
      int guard = 0;
      s_tdata  = pix_buf[i];
      s_tlast  = (bad_idx >= 0) ? (i == bad_idx) : (i == np - 1);
      s_tvalid = 1'b0;
      while (!done) begin
        if (!s_tvalid) s_tvalid = stall_en ? ($urandom_range(7) != 0) : 1'b1;
        @(negedge clk);
        done = s_tvalid && s_tready;
        tick();
        guard++;
        if (guard > 2000) begin
          n_chk++;
          $display("FAIL pix_timeout: pixel %0d not accepted in %0d cycles", i, guard);
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // stop_after<0 runs the full frame; otherwise stops after that many pixels.
  task automatic run_frame(input logic [2:0] sel, input bit fixed, input int bad_idx,
                           input int stop_after);
    int n, np;
    logic [W-1:0] ys, yb, p;
    n  = (sel >= 3'd5) ? 128 : (4 << sel);
    np = n * n;
    ys = fixed ? W'(1) : rnd_word();
    yb = fixed ? W'(2) : rnd_word();
    gpio_N_sel = sel; cfg_ys = ys; cfg_yb = yb; start = 1'b1;
    tick();
    start = 1'b0;
    gpio_N_sel = 3'($urandom); cfg_ys = rnd_word(); cfg_yb = rnd_word();
    exp_q.push_back('{ys, 1'b0});
    exp_q.push_back('{yb, 1'b0});
    pix_buf.delete();
    for (int i = 0; i < np; i++) begin
      p = fixed ? W'(16 + i) : rnd_word();
      pix_buf.push_back(p);
      exp_q.push_back('{p, (i == np - 1)});
    end
    drive_pix((stop_after < 0) ? np : stop_after, np, bad_idx);
    if (stop_after < 0) begin
      exp_fd++;
      tick(); tick();
      chk("drained", 64'(exp_q.size()), 64'(0));
      chk("frame_done_cnt", 64'(fd_cnt), 64'(exp_fd));
      chk("idle_after", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state with provocative inputs
    s_tvalid = 1'b1; start = 1'b1;
    #3;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_err_last", 64'(err_last), 64'(0));
    s_tvalid = 1'b0; start = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Directed 4x4 frame: 1, 2, 0x10..0x1F
    run_frame(3'd0, 1'b1, -1, -1);
    chk("err_clean", 64'(err_last), 64'(0));

    // 128x128 with random stalls, then sel=7 decodes to the same size
    stall_en = 1'b1;
    run_frame(3'd5, 1'b0, -1, -1);
    stall_en = 1'b0;
    run_frame(3'd7, 1'b0, -1, -1);

    // Start pulse and N change mid-frame are ignored
    fork
      run_frame(3'd1, 1'b0, -1, -1);
      begin
        repeat (30) tick();
        chk("mid_busy", 64'(busy), 64'(1));
        gpio_N_sel = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
      end
    join

    // Asynchronous reset after 5 pixels of an 8x8 frame
    run_frame(3'd1, 1'b0, -1, 5);
    s_tdata = rnd_word(); s_tvalid = 1'b1;
    #1;
    chk("pre_rst_valid", 64'(m_tvalid), 64'(1));
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("arst_m_tlast", 64'(m_tlast), 64'(0));
    chk("arst_s_tready", 64'(s_tready), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_frame_done", 64'(frame_done), 64'(0));
    exp_q.delete();
    s_tvalid = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    chk("no_fd_after_abort", 64'(fd_cnt), 64'(exp_fd));
    chk("idle_after_abort", 64'(busy), 64'(0));
    run_frame(3'd1, 1'b0, -1, -1);

    // Upstream tlast on pixel 3 of 16; output tlast still on pixel 16
    chk("err_before", 64'(err_last), 64'(0));
    run_frame(3'd0, 1'b0, 2, -1);
    chk("err_set", 64'(err_last), 64'(EXP_ERR));
    run_frame(3'd0, 1'b0, -1, -1);
    chk("err_sticky", 64'(err_last), 64'(EXP_ERR));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_adain_packer.md
AXIS_ADAIN_PACKER -- requirements
Module: axis_adain_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 48: data width of every stream word (pixel, ys, yb).
REQ-002 SHALL have parameter N_MAX, default 128: largest feature-map side N; the pixel counter is sized $clog2(N_MAX*N_MAX+1) bits.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port gpio_N_sel, input, 3: N select; 0..5 -> N = 4, 8, 16, 32, 64, 128; 6 and 7 -> N = 128.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin one frame.
REQ-007 SHALL have port cfg_ys, input, WIDTH: style scale word sent as frame word 0.
REQ-008 SHALL have port cfg_yb, input, WIDTH: style bias word sent as frame word 1.
REQ-009 SHALL have port s_axis_tdata, input, WIDTH: upstream pixel data.
REQ-010 SHALL have port s_axis_tvalid, input, 1: upstream pixel valid.
REQ-011 SHALL have port s_axis_tready, output, 1: upstream pixel ready.
REQ-012 SHALL have port s_axis_tlast, input, 1: upstream end-of-frame marker (used only under the Configuration macro).
REQ-013 SHALL have port m_axis_tdata, output, WIDTH: frame word toward the AdaIN stream slave.
REQ-014 SHALL have port m_axis_tvalid, output, 1: frame word valid.
REQ-015 SHALL have port m_axis_tready, input, 1: downstream ready.
REQ-016 SHALL have port m_axis_tlast, output, 1: high on the last pixel of the frame only.
REQ-017 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-018 SHALL have port frame_done, output, 1: one-cycle pulse in the cycle after the last pixel handshake.
REQ-019 SHALL have port err_last, output, 1: sticky tlast-mismatch flag.

Function
REQ-020 SHALL implement states IDLE, YS, YB, PIX; transfer = tvalid && tready in the same cycle.
REQ-021 SHALL, in IDLE with start high, latch cfg_ys, cfg_yb and the decoded N, load the pixel counter with N*N, and go to YS next cycle; start outside IDLE is ignored.
REQ-022 SHALL in YS drive m_axis_tvalid=1 and m_axis_tdata=latched ys, holding both stable until transfer, then go to YB.
REQ-023 SHALL in YB drive latched yb the same way, then go to PIX.
REQ-024 SHALL in PIX pass through combinationally: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready; zero added latency.
REQ-025 SHALL hold s_axis_tready=0 in IDLE, YS and YB.
REQ-026 SHALL decrement the counter on each PIX transfer and drive m_axis_tlast=1 only while in PIX with counter==1.
REQ-027 SHALL, on the transfer with counter==1, return to IDLE and pulse frame_done next cycle; a start in that same frame_done cycle is accepted.
REQ-028 SHALL keep m_axis_tlast=0 in YS and YB; the frame is exactly N*N+2 words.
REQ-029 SHALL ignore gpio_N_sel, cfg_ys and cfg_yb changes while busy.
REQ-030 SHALL tolerate tvalid/tready stalls of any length in any state without loss or duplication.

Reset
REQ-031 SHALL, while rstn=0, force state=IDLE, counter=0, latched ys/yb/N=0, busy=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0, frame_done=0, err_last=0.
REQ-032 SHALL abandon a frame in progress on reset assertion; the next frame begins only after a new start.

Configuration
REQ-033 SHALL, with macro AXIS_ADAIN_PACKER_LAST_CHK_EN defined, set err_last on a PIX transfer where s_axis_tlast != (counter==1); err_last clears only on reset.
REQ-034 SHALL, without AXIS_ADAIN_PACKER_LAST_CHK_EN, tie err_last to 0 and ignore s_axis_tlast; all other behaviour identical.

Verification
REQ-035 SHALL cover: sel=0, ys=0x1, yb=0x2, 16 pixels 0x10..0x1F, tready=1 -> 18 words 0x1,0x2,0x10..0x1F, tlast only on 0x1F, frame_done once.
REQ-036 SHALL cover: sel=5, random tready/tvalid stalls -> 16386 words in order, tlast on word 16386, ys/yb held stable while stalled.
REQ-037 SHALL cover: sel=7 -> N=128 behaviour identical to sel=5.
REQ-038 SHALL cover: start pulse during PIX plus gpio_N_sel change -> ignored, frame length unchanged.
REQ-039 SHALL cover: rstn low mid-PIX at pixel 5 of sel=1 -> all outputs at reset values asynchronously; next start gives a full 66-word frame.
REQ-040 SHALL cover, with macro defined: s_axis_tlast on pixel 3 of a 16-pixel frame -> err_last=1 sticky, output tlast still on pixel 16; without macro err_last stays 0.
